// File: rtl/hdmi_timing_pkg.sv
// Shared types and constants for the HDMI FIFO pixel reader: read-side FSM
// states, default 1280x720 timing, and the counter width helper.
package hdmi_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESYNC = 2'd3
    } rd_state_t;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FP_DEF     = 110;
    localparam int H_SYNC_DEF   = 40;
    localparam int H_BP_DEF     = 220;
    localparam int V_ACTIVE_DEF = 720;
    localparam int V_FP_DEF     = 5;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_BP_DEF     = 20;

    // Bits needed to hold 0..total-1; never less than one bit.
    function automatic int cnt_width(input int total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/hdmi_fifo_pixel_reader_if.sv
// Read port of the zoom-to-HDMI prefetch FIFO. The head word is visible
// whenever rd_vld is high; rd_en pops it on the same clock edge.
interface hdmi_fifo_pixel_reader_if;
    logic        rd_en;
    logic        rd_vld;
    logic [23:0] rd_data;

    modport master (
        output rd_en,
        input  rd_vld,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        output rd_vld,
        output rd_data
    );
endinterface

// File: rtl/hdmi_timing_cnt.sv
// Free-running raster position counters with the look-ahead decode used by
// the reader: data enable, syncs and start-of-frame for the current position.
// Line/frame order is active, front porch, sync, back porch.
module hdmi_timing_cnt
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic rd_clk,
    input  logic rd_rst_n,
    output logic de_nxt,
    output logic hs_nxt,
    output logic vs_nxt,
    output logic sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = cnt_width(H_TOTAL);
    localparam int V_W     = cnt_width(V_TOTAL);

    // Compare constants carry one spare bit so a sync ending exactly at the
    // total does not wrap.
    localparam logic [H_W:0] H_LAST   = (H_W + 1)'(H_TOTAL - 1);
    localparam logic [H_W:0] H_DE_END = (H_W + 1)'(H_ACTIVE);
    localparam logic [H_W:0] HS_START = (H_W + 1)'(H_ACTIVE + H_FP);
    localparam logic [H_W:0] HS_END   = (H_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W:0] V_LAST   = (V_W + 1)'(V_TOTAL - 1);
    localparam logic [V_W:0] V_DE_END = (V_W + 1)'(V_ACTIVE);
    localparam logic [V_W:0] VS_START = (V_W + 1)'(V_ACTIVE + V_FP);
    localparam logic [V_W:0] VS_END   = (V_W + 1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic [H_W:0]   h_ext;
    logic [V_W:0]   v_ext;

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    // Pixel and line counters; the line counter steps on each line wrap.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_ext == H_LAST) begin
            h_cnt <= '0;
            if (v_ext == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign de_nxt = (h_ext < H_DE_END) && (v_ext < V_DE_END);
    assign hs_nxt = (h_ext >= HS_START) && (h_ext < HS_END);
    assign vs_nxt = (v_ext >= VS_START) && (v_ext < VS_END);
    assign sof    = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/hdmi_fifo_pixel_reader.sv
// Read-side consumer of the 24-bit zoom-to-HDMI prefetch FIFO. Generates the
// raster, pops one pixel per active cycle once locked to a frame start, and
// substitutes FILL_COLOR on underflow until the next frame start with data.
// Optional feature macro HDMI_RD_UNDERFLOW_CNT_EN adds a 16-bit saturating
// count of fill-colour active cycles emitted while streaming.
//
// state  | meaning
// IDLE   | streaming disabled, no pops
// ARM    | enabled, waiting for h=0,v=0 with FIFO data
// RUN    | locked, popping every active cycle
// RESYNC | underflowed, waiting for h=0,v=0 with FIFO data
module hdmi_fifo_pixel_reader
    import hdmi_timing_pkg::*;
#(
    parameter int          H_ACTIVE   = H_ACTIVE_DEF,
    parameter int          H_FP       = H_FP_DEF,
    parameter int          H_SYNC     = H_SYNC_DEF,
    parameter int          H_BP       = H_BP_DEF,
    parameter int          V_ACTIVE   = V_ACTIVE_DEF,
    parameter int          V_FP       = V_FP_DEF,
    parameter int          V_SYNC     = V_SYNC_DEF,
    parameter int          V_BP       = V_BP_DEF,
    parameter bit          SYNC_POL   = 1'b1,
    parameter logic [23:0] FILL_COLOR = 24'h000000
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst_n,
    input  logic                      en,
    hdmi_fifo_pixel_reader_if.master  fifo,
    output logic                      hdmi_hs,
    output logic                      hdmi_vs,
    output logic                      hdmi_de,
    output logic [23:0]               hdmi_rgb,
    output logic                      frame_start,
    output logic                      underflow,
    input  logic                      underflow_clr
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]               underflow_cnt
`endif
);

    logic      de_nxt;
    logic      hs_nxt;
    logic      vs_nxt;
    logic      sof;
    rd_state_t state;
    rd_state_t state_nxt;
    logic      pop;
    logic      uf_set;

    hdmi_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .de_nxt   (de_nxt),
        .hs_nxt   (hs_nxt),
        .vs_nxt   (vs_nxt),
        .sof      (sof)
    );

    // FSM state register.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pop decision; ARM and RESYNC lock on the same frame
    // start that pops the first pixel. rd_vld only matters on active cycles.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        uf_set    = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ARM;
                end
                ST_ARM, ST_RESYNC: begin
                    if (sof && fifo.rd_vld) begin
                        state_nxt = ST_RUN;
                        pop       = de_nxt;
                    end
                end
                ST_RUN: begin
                    pop = de_nxt && fifo.rd_vld;
                    if (de_nxt && !fifo.rd_vld) begin
                        state_nxt = ST_RESYNC;
                        uf_set    = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign fifo.rd_en = pop;

    // Registered output bundle, one cycle behind the raster position.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            hdmi_hs     <= ~SYNC_POL;
            hdmi_vs     <= ~SYNC_POL;
            hdmi_de     <= 1'b0;
            hdmi_rgb    <= '0;
            frame_start <= 1'b0;
        end else begin
            hdmi_hs     <= hs_nxt ? SYNC_POL : ~SYNC_POL;
            hdmi_vs     <= vs_nxt ? SYNC_POL : ~SYNC_POL;
            hdmi_de     <= de_nxt;
            frame_start <= sof;
            if (pop) begin
                hdmi_rgb <= fifo.rd_data;
            end else if (de_nxt) begin
                hdmi_rgb <= FILL_COLOR;
            end else begin
                hdmi_rgb <= '0;
            end
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            underflow <= 1'b0;
        end else if (uf_set) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

`ifdef HDMI_RD_UNDERFLOW_CNT_EN
    logic fill_active;

    assign fill_active = en && de_nxt && !pop &&
                         ((state == ST_RUN) || (state == ST_RESYNC));

    // Saturating count of active cycles filled while locked or resyncing.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            underflow_cnt <= '0;
        end else if (underflow_clr) begin
            underflow_cnt <= '0;
        end else if (fill_active && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_fifo_pixel_reader.sv
// Bench for hdmi_fifo_pixel_reader with a 7x5 raster (H 4/1/1/1, V 2/1/1/1).
module tb_hdmi_fifo_pixel_reader;

    localparam int          HA   = 4;
    localparam int          HF   = 1;
    localparam int          HSW  = 1;
    localparam int          HB   = 1;
    localparam int          VA   = 2;
    localparam int          VF   = 1;
    localparam int          VSW  = 1;
    localparam int          VB   = 1;
    localparam int          HT   = HA + HF + HSW + HB;
    localparam int          VT   = VA + VF + VSW + VB;
    localparam int          FT   = HT * VT;
    localparam logic [23:0] FILL = 24'h00F00D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        hs, vs, de, fs, uf;
    logic [23:0] rgb;
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
    logic [15:0] ucnt;
`endif

    hdmi_fifo_pixel_reader_if fifo_if ();

    hdmi_fifo_pixel_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .SYNC_POL (1'b1), .FILL_COLOR (FILL)
    ) dut (
        .rd_clk        (clk),
        .rd_rst_n      (rst_n),
        .en            (en),
        .fifo          (fifo_if),
        .hdmi_hs       (hs),
        .hdmi_vs       (vs),
        .hdmi_de       (de),
        .hdmi_rgb      (rgb),
        .frame_start   (fs),
        .underflow     (uf),
        .underflow_clr (clr)
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (ucnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raster position, FIFO contents and a lock flag.
    int          t;
    bit          en_prev;
    bit          synced;
    bit          locked_once;
    logic [23:0] q[$];
    bit          m_uf;
    int          m_cnt;

    typedef struct {
        int          p;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (pos %0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        t           = 0;
        en_prev     = 1'b0;
        synced      = 1'b0;
        locked_once = 1'b0;
        m_uf        = 1'b0;
        m_cnt       = 0;
    endtask

    // One pixel clock: drive inputs, check rd_en, clock, check outputs.
    task automatic cycle(input bit en_i, input bit gate_i, input bit clr_i);
        int          h, v;
        bit          de_m, sof_m, stream, pop, ufset, vld;
        logic [23:0] data;
        logic        e_hs, e_vs;
        logic [23:0] e_rgb;
        h     = t % HT;
        v     = (t / HT) % VT;
        de_m  = (h < HA) && (v < VA);
        sof_m = (h == 0) && (v == 0);
        vld   = gate_i && (q.size() > 0);
        data  = vld ? q[0] : 24'($urandom);
        en    = en_i;
        clr   = clr_i;
        fifo_if.rd_vld  = vld;
        fifo_if.rd_data = data;
        #1;
        stream = en_i && en_prev;
        pop    = 1'b0;
        ufset  = 1'b0;
        if (stream) begin
            if (!synced && sof_m && vld) begin
                synced      = 1'b1;
                locked_once = 1'b1;
            end
            if (synced && de_m) begin
                if (vld) pop = 1'b1;
                else ufset = 1'b1;
            end
        end
        chk("rd_en", fifo_if.rd_en, pop);
        e_hs  = (h >= HA + HF) && (h < HA + HF + HSW);
        e_vs  = (v >= VA + VF) && (v < VA + VF + VSW);
        e_rgb = pop ? data : (de_m ? FILL : 24'h0);
        if (ufset) m_uf = 1'b1;
        else if (clr_i) m_uf = 1'b0;
        if (clr_i) m_cnt = 0;
        else if (stream && locked_once && de_m && !pop && m_cnt < 65535) m_cnt++;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (ufset) synced = 1'b0;
        if (!en_i) begin
            synced      = 1'b0;
            locked_once = 1'b0;
        end
        en_prev = en_i;
        t++;
        #1;
        chk("hdmi_hs", hs, e_hs);
        chk("hdmi_vs", vs, e_vs);
        chk("hdmi_de", de, de_m);
        chk("frame_start", fs, sof_m);
        chk("hdmi_rgb", rgb, e_rgb);
        chk("underflow", uf, m_uf);
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
        chk("underflow_cnt", ucnt, m_cnt);
`endif
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_hs", hs, 0);
        chk("rst_vs", vs, 0);
        chk("rst_de", de, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_fs", fs, 0);
        chk("rst_uf", uf, 0);
        chk("rst_rd_en", fifo_if.rd_en, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_sof(input bit en_i);
        for (int k = 0; k < FT && (t % FT) != 0; k++) cycle(en_i, 1'b1, 1'b0);
    endtask

    initial begin
        logic [23:0] got[$];
        fifo_if.rd_vld  = 1'b0;
        fifo_if.rd_data = '0;

        tbl.push_back(vec_t'{0,  1'b0, 1'b0, 1'b1, FILL});
        tbl.push_back(vec_t'{3,  1'b0, 1'b0, 1'b1, FILL});
        tbl.push_back(vec_t'{4,  1'b0, 1'b0, 1'b0, 24'h0});
        tbl.push_back(vec_t'{5,  1'b1, 1'b0, 1'b0, 24'h0});
        tbl.push_back(vec_t'{6,  1'b0, 1'b0, 1'b0, 24'h0});
        tbl.push_back(vec_t'{7,  1'b0, 1'b0, 1'b1, FILL});
        tbl.push_back(vec_t'{14, 1'b0, 1'b0, 1'b0, 24'h0});
        tbl.push_back(vec_t'{21, 1'b0, 1'b1, 1'b0, 24'h0});
        tbl.push_back(vec_t'{26, 1'b1, 1'b1, 1'b0, 24'h0});
        tbl.push_back(vec_t'{27, 1'b0, 1'b1, 1'b0, 24'h0});
        tbl.push_back(vec_t'{28, 1'b0, 1'b0, 1'b0, 24'h0});
        tbl.push_back(vec_t'{35, 1'b0, 1'b0, 1'b1, FILL});

        #2;
        apply_reset();

        // Idle raster with the enable low, checked against the hand table.
        for (int n = 0; n < 40; n++) begin
            cycle(1'b0, 1'b1, 1'b0);
            foreach (tbl[i]) begin
                if (tbl[i].p == t - 1) begin
                    chk("tbl_hs", hs, tbl[i].hs);
                    chk("tbl_vs", vs, tbl[i].vs);
                    chk("tbl_de", de, tbl[i].de);
                    chk("tbl_rgb", rgb, tbl[i].rgb);
                end
            end
        end

        // Preloaded FIFO streams 1..8 over the next full frame.
        for (int i = 1; i <= 8; i++) q.push_back(24'(i));
        wait_sof(1'b1);
        got.delete();
        for (int k = 0; k < FT; k++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (de) got.push_back(rgb);
        end
        chk("stream_len", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) chk("stream_px", got[i], 24'(i + 1));
        chk("stream_no_uf", uf, 0);

        // rd_vld drops at the third active pixel, then a lone clear.
        for (int i = 9; i <= 16; i++) q.push_back(24'(i));
        for (int k = 0; k < FT; k++) begin
            cycle(1'b1, k != 2, k == 20);
            if (k == 2) begin
                chk("uf_fill_px", rgb, FILL);
                chk("uf_set", uf, 1);
            end
            if (k == 3) chk("uf_no_pop", q.size(), 6);
            if (k == 20) chk("uf_cleared", uf, 0);
        end
        chk("resync_wait", q.size(), 6);

        // Resync pops 11..16, then a new underflow collides with a clear.
        for (int k = 0; k < FT; k++) begin
            cycle(1'b1, 1'b1, k == 9);
            if (k == 0) chk("resync_px", rgb, 24'd11);
            if (k == 9) chk("set_beats_clr", uf, 1);
        end

        // Enable dropped mid-line: no pop that cycle, fill afterwards.
        for (int i = 17; i <= 24; i++) q.push_back(24'(i));
        for (int k = 0; k < FT; k++) begin
            cycle(k < 2, 1'b1, 1'b0);
            if (k == 1) chk("en_px", rgb, 24'd18);
            if (k == 2) chk("en_low_fill", rgb, FILL);
            if (k == 8) chk("en_low_fill2", rgb, FILL);
        end
        chk("en_low_no_pop", q.size(), 6);

        // Mid-frame reset, then randomized traffic against the model.
        for (int k = 0; k < 17; k++) cycle(1'b1, 1'b1, 1'b0);
        apply_reset();
        begin
            bit en_r;
            en_r = 1'b1;
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(199) == 0) en_r = ~en_r;
                if (q.size() < 6 && $urandom_range(3) != 0) begin
                    q.push_back(24'($urandom));
                    q.push_back(24'($urandom));
                end
                cycle(en_r, $urandom_range(9) != 0, $urandom_range(29) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
